// File: rtl/evt_pulse_gen.sv
// Programmable event-pulse generator: periodic one-cycle evt pulses, burst or continuous.
// Optional evt-driven toggle output enabled by `EVT_PULSE_GEN_TOGGLE_EN.
module evt_pulse_gen #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   period,
  input  logic [BURST_W-1:0] burst,
  output logic               evt,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] evt_cnt
`ifdef EVT_PULSE_GEN_TOGGLE_EN
  ,
  output logic               tgl
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [BURST_W-1:0] EVT_ONE = BURST_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   per_q, per_d;
  logic [BURST_W-1:0] bur_q, bur_d;
  logic [BURST_W-1:0] evt_cnt_q, evt_cnt_d;
  logic               evt_q, evt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    per_d     = per_q;
    bur_d     = bur_q;
    evt_cnt_d = evt_cnt_q;
    evt_d     = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d   = ST_RUN;
          per_d     = (period == '0) ? CNT_ONE : period;
          bur_d     = burst;
          evt_cnt_d = '0;
          cnt_d     = CNT_ONE;
          busy_d    = 1'b1;
        end
      end
      ST_RUN: begin
        // Completion is seen one edge after the final event, so busy spans that event cycle.
        if (stop) begin
          state_d = ST_IDLE;
        end else if (bur_q != '0 && evt_cnt_q == bur_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
          if (cnt_q == per_q) begin
            evt_d     = 1'b1;
            cnt_d     = CNT_ONE;
            evt_cnt_d = evt_cnt_q + EVT_ONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      per_q     <= '0;
      bur_q     <= '0;
      evt_cnt_q <= '0;
      evt_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      bur_q     <= bur_d;
      evt_cnt_q <= evt_cnt_d;
      evt_q     <= evt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign evt     = evt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign evt_cnt = evt_cnt_q;

`ifdef EVT_PULSE_GEN_TOGGLE_EN
  logic tgl_q, tgl_d;

  always_comb begin
    tgl_d = tgl_q ^ evt_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tgl_q <= 1'b0;
    end else begin
      tgl_q <= tgl_d;
    end
  end

  assign tgl = tgl_q;
`endif

endmodule

// File: tb/tb_evt_pulse_gen.sv
// Scoreboard bench for evt_pulse_gen: a schedule-based reference model predicts outputs per edge.
module tb_evt_pulse_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [15:0] period;
  logic [7:0]  burst;
  logic        evt, busy, done;
  logic [7:0]  evt_cnt;
  logic        tgl_obs;

  evt_pulse_gen #(.CNT_W(16), .BURST_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .period(period), .burst(burst),
    .evt(evt), .busy(busy), .done(done), .evt_cnt(evt_cnt)
`ifdef EVT_PULSE_GEN_TOGGLE_EN
    , .tgl(tgl_obs)
`endif
  );

`ifndef EVT_PULSE_GEN_TOGGLE_EN
  assign tgl_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  // {evt, busy, done, tgl, evt_cnt[7:0]}
  logic [11:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  int cyc_n = 0;

  // Reference model: RUN is described by edges elapsed since the accepted start.
  typedef enum {M_IDLE, M_RUN, M_DONE} mst_t;
  mst_t m_st = M_IDLE;
  int   m_e = 0, m_p = 1, m_b = 0, m_cnt = 0;
  bit   m_tgl = 1'b0;

  initial begin
    forever begin
      bit x_evt, x_busy, x_done;
      @(posedge clk);
      x_evt = 0; x_busy = 0; x_done = 0;
      if (!rst_n) begin
        m_st = M_IDLE; m_cnt = 0; m_tgl = 0;
      end else begin
        case (m_st)
          M_IDLE: begin
            if (start && !stop) begin
              m_p   = (period == 16'd0) ? 1 : int'(period);
              m_b   = int'(burst);
              m_e   = 0;
              m_cnt = 0;
              m_st  = M_RUN;
              x_busy = 1;
            end
          end
          M_RUN: begin
            m_e++;
            if (stop) begin
              m_st = M_IDLE;
            end else if (m_b != 0 && m_e == m_p * m_b + 1) begin
              m_st = M_DONE;
              x_done = 1;
            end else begin
              x_busy = 1;
              x_evt  = (m_e % m_p) == 0;
              m_cnt  = (m_e / m_p) % 256;
            end
          end
          default: m_st = M_IDLE;
        endcase
`ifdef EVT_PULSE_GEN_TOGGLE_EN
        if (x_evt) m_tgl = ~m_tgl;
`endif
      end
      exp_q.push_back({x_evt, x_busy, x_done, m_tgl, 8'(m_cnt)});
    end
  end

  initial begin
    forever begin
      logic [11:0] act, want;
      @(negedge clk);
      cyc_n++;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        act  = {evt, busy, done, tgl_obs, evt_cnt};
        tests++;
        if (act !== want) begin
          fails++;
          $display("FAIL outputs@cycle%0d got evt=%b busy=%b done=%b tgl=%b cnt=%0d want evt=%b busy=%b done=%b tgl=%b cnt=%0d",
                   cyc_n, act[11], act[10], act[9], act[8], act[7:0],
                   want[11], want[10], want[9], want[8], want[7:0]);
        end
      end
    end
  end

  task automatic cyc(input logic s, input logic sp, input int p, input int b);
    start  = s;
    stop   = sp;
    period = 16'(p);
    burst  = 8'(b);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, $urandom_range(0, 15), $urandom_range(0, 7));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; stop = 1'b0; period = 16'd3; burst = 8'd2;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(5);

    // Burst of 3 at period 4
    cyc(1, 0, 4, 3);
    idle(18);

    // Period 0, continuous, across the evt_cnt wrap
    cyc(1, 0, 0, 0);
    idle(270);
    cyc(0, 1, 0, 0);
    idle(3);

    // Stop on an event-due edge
    cyc(1, 0, 5, 0);
    idle(9);
    cyc(0, 1, 5, 0);
    idle(4);

    // Start during RUN is ignored
    cyc(1, 0, 3, 0);
    idle(4);
    cyc(1, 0, 9, 0);
    idle(10);
    cyc(0, 1, 0, 0);

    // Start and stop together in IDLE
    cyc(1, 1, 2, 2);
    cyc(1, 1, 2, 2);
    idle(3);

    // Toggle burst, then reset mid-run
    cyc(1, 0, 2, 4);
    idle(12);
    cyc(1, 0, 2, 4);
    idle(5);
    rst_n = 1'b0;
    cyc(0, 0, 2, 4);
    rst_n = 1'b1;
    idle(4);

    // Randomized traffic
    repeat (1500) begin
      rst_n = ($urandom_range(0, 199) != 0);
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
          $urandom_range(0, 6), $urandom_range(0, 5));
    end
    rst_n = 1'b1;
    idle(20);

    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/evt_pulse_gen.md
# evt_pulse_gen

Programmable event-pulse generator that drives the event-driven toggle/display stage directly downstream of it. Once started, it emits single-cycle `evt` pulses at a fixed period, either for a fixed burst count or continuously until stopped. It reports progress through a busy flag, an event counter and a one-cycle completion pulse. All outputs are registered.

## Interface
Parameters:
- `CNT_W`, 16, width of the period value and of the period counter
- `BURST_W`, 8, width of the burst value and of the event counter

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  start request, sampled only in IDLE
- `stop`  in  1  abort request, sampled in any state
- `period`  in  CNT_W  cycles between events; 0 is treated as 1; latched on an accepted start
- `burst`  in  BURST_W  number of events to emit; 0 means continuous; latched on an accepted start
- `evt`  out  1  one-cycle event pulse
- `busy`  out  1  high while in RUN
- `done`  out  1  one-cycle pulse when a burst completes
- `evt_cnt`  out  BURST_W  number of events emitted since the last accepted start
- `tgl`  out  1  flips on every `evt`; present only when the feature macro is defined

## Operation
- States:
  - IDLE: the reset state.
  - RUN: events are being generated.
  - DONE: lasts exactly one cycle, then returns to IDLE.
- Reset (`rst_n`=0 at an edge):
  - state=IDLE.
  - `evt`=0, `busy`=0, `done`=0, `evt_cnt`=0, `tgl`=0.
  - Period counter=0; latched period and burst=0.
- IDLE → RUN: on `start`=1 with `stop`=0.
  - Latch `period` (0 is stored as 1) and `burst`.
  - Clear `evt_cnt`.
  - Load the period counter with 1.
- IDLE with `start` and `stop` both high: remain in IDLE; nothing is latched.
- RUN, each cycle:
  - If the counter equals the latched period: assert `evt` next cycle, reload the counter with 1, and increment `evt_cnt`.
  - Otherwise: increment the counter.
- RUN → DONE: when latched burst≠0 and the increment makes `evt_cnt` equal to the latched burst.
- DONE: `done`=1 and `busy`=0 for one cycle, then IDLE. `evt_cnt` holds its final value.
- `stop`=1 in RUN:
  - Go to IDLE at that edge.
  - No `evt` and no `done`, including when an event was due at the same edge (stop wins).
  - `evt_cnt` holds its value.
- `start` while in RUN or DONE: ignored. Input `period`/`burst` changes during RUN have no effect.
- Continuous mode (burst=0): `evt_cnt` wraps from 2^BURST_W−1 to 0 and generation continues.
- Period counter arithmetic is CNT_W bits unsigned. The maximum period is 2^CNT_W−1, and the counter never wraps.

## Timing
- Latency:
  - `start` accepted at edge 0: `busy`=1 from edge 0.
  - The first `evt` is high in the cycle after edge P (P = latched period).
  - Subsequent events follow every P cycles.
- P=1: `evt` is high in every cycle from edge 1 until termination.
- Counter and completion timing:
  - `evt` and the `evt_cnt` increment update at the same edge.
  - Final event of a burst at edge k: `done`=1 and `busy`=0 after edge k+1; state is IDLE after edge k+2.
- Restart: a new `start` is accepted from the first IDLE cycle, i.e. one cycle after `done`.
- Reset mid-run: all outputs return to their reset values at the reset edge. Any pending event is discarded.

## Configuration
- Macro: `EVT_PULSE_GEN_TOGGLE_EN`.
- Defined:
  - Port `tgl` exists and is reset to 0.
  - `tgl` inverts at every edge where `evt` is asserted, so it changes in the same cycle `evt` goes high.
  - `stop` and `start` do not alter `tgl`.
- Undefined: port `tgl` and its register are absent. All other behaviour is identical.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `start`=1 → all outputs 0 and state IDLE. Release reset: no `evt` unless a fresh `start` is sampled.
- Burst: period=4, burst=3, start at edge 0 → `evt` after edges 4, 8 and 12; `evt_cnt` 1/2/3; `done` after edge 13; `busy` low from edge 13.
- Period 0 and continuous with wrap: period=0, burst=0, BURST_W=8 → `evt` every cycle; `evt_cnt` wraps from 255 to 0 after 256 events; `done` never asserts.
- Stop collision: period=5, burst=0, `stop` at edge 10 (an event-due edge) → no `evt` at 10; `busy`=0 and `evt_cnt`=1 after edge 10; no `done`.
- Ignored and simultaneous requests:
  - `start` pulsed during RUN with period=9 → period stays at the originally latched 3.
  - `start`+`stop` in IDLE → `busy` stays 0.
- Toggle (macro defined): period=2, burst=4 → `tgl` sequence 1, 0, 1, 0 at each `evt`, ending at 0. Reset mid-run (macro defined) → `tgl`=0 and `evt_cnt`=0.
